// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: register word indices, source limit and CLAIM word packing
package interrupt_controller_pkg;

    localparam int MAX_SRC = 6;

    localparam logic [5:0] REG_PENDING = 6'd0;
    localparam logic [5:0] REG_MASK    = 6'd1;
    localparam logic [5:0] REG_MODE    = 6'd2;
    localparam logic [5:0] REG_CTRL    = 6'd3;
    localparam logic [5:0] REG_CLAIM   = 6'd4;
    localparam logic [5:0] REG_RAW     = 6'd5;

    typedef struct packed {
        logic       valid;
        logic [2:0] index;
    } claim_t;

    function automatic logic [31:0] claim_word(claim_t c);
        return {c.valid, 28'b0, c.index};
    endfunction

endpackage

// File: rtl/interrupt_controller_irq_sync_edge.sv
// irq_sync_edge: two-flop synchroniser for one request plus a delayed copy for rise detection
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);
    logic s1, s2, s3;

    // s1/s2 resolve metastability; s3 lags s2 so a rise is seen exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: memory-mapped pending/mask/mode/enable block driving intr and int_level
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          N_SRC     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          addr,
    input  logic [31:0]          w_data,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic [31:0]          r_data,
    output logic                 sel,
    input  logic [N_SRC-1:0]     irq_src,
    output logic                 intr,
    output logic [MAX_SRC-1:0]   int_level
);
    logic [N_SRC-1:0]   pending, mask, mode, raw, rise, set, w1c, masked;
    logic               ctrl, wr;
    logic [5:0]         idx;
    logic [MAX_SRC-1:0] lvl;
    claim_t             claim;
    logic               unused_bits;

    assign sel         = addr[31:8] == BASE_ADDR[31:8];
    assign idx         = addr[7:2];
    assign wr          = sel & mem_write;
    assign unused_bits = ^{addr[1:0], w_data};

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        irq_sync_edge u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .async_in (irq_src[i]),
            .level    (raw[i]),
            .rise     (rise[i])
        );
    end

    assign set    = (mode & rise) | (~mode & raw);
    assign w1c    = (wr && idx == REG_PENDING) ? w_data[N_SRC-1:0] : '0;
    assign masked = pending & mask;

    // lowest enabled pending index wins: scan downwards so the last hit is the smallest
    always_comb begin
        claim = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                claim.valid = 1'b1;
                claim.index = 3'(i);
            end
        end
    end

    // register read mux; r_data is 0 unless this block is being loaded from
    always_comb begin
        r_data = '0;
        if (sel && mem_read) begin
            case (idx)
                REG_PENDING: r_data[N_SRC-1:0] = pending;
                REG_MASK:    r_data[N_SRC-1:0] = mask;
                REG_MODE:    r_data[N_SRC-1:0] = mode;
                REG_CTRL:    r_data[0]         = ctrl;
                REG_CLAIM:   r_data            = claim_word(claim);
                REG_RAW:     r_data[N_SRC-1:0] = raw;
                default:     r_data            = '0;
            endcase
        end
    end

    // zero-extend the masked vector to the CPU's fixed interrupt-level width
    always_comb begin
        lvl = '0;
        lvl[N_SRC-1:0] = masked;
    end

    // register file; a hardware set in the same cycle as a W1C keeps the bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
            ctrl    <= 1'b0;
        end else begin
            pending <= (pending & ~w1c) | set;
            if (wr && idx == REG_MASK) mask <= w_data[N_SRC-1:0];
            if (wr && idx == REG_MODE) mode <= w_data[N_SRC-1:0];
            if (wr && idx == REG_CTRL) ctrl <= w_data[0];
        end
    end

    // registered CPU-facing outputs, one edge behind the registers they reflect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr      <= 1'b0;
            int_level <= '0;
        end else begin
            intr      <= ctrl & |masked;
            int_level <= lvl;
        end
    end

endmodule
